pdh_adc_decimator: RTL and testbench

Conditioning stage directly upstream of pdh_core on the ADC stream.
- Consumes the 32-bit ADC AXI-stream word (channel A in [15:0], channel B in [31:16]; each lane is 14-bit two's-complement, sign-extended to 16 bits).
- Per channel: subtracts a PS-programmed DC offset with saturation, then box-car averages and decimates by 2^N.
- Emits a 16-bit-per-lane stream with a single-cycle valid for pdh_core's adc_tdata_i/adc_tvalid_i.

---
 rtl/pdh_pkg.sv | 25 ++
 rtl/pdh_lane_avg.sv | 58 +++++
 rtl/pdh_adc_decimator.sv | 110 +++++++++++
 tb/tb_pdh_adc_decimator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdh_pkg.sv
// Shared types, sizes and the saturation helper for the PDH ADC conditioning path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pdh_pkg;

  localparam int LANE_WIDTH   = 16;
  localparam int MAX_DEC_LOG2 = 8;
  localparam int ACC_WIDTH    = 24;

  typedef logic signed [LANE_WIDTH-1:0] lane_t;

  typedef struct packed {
    lane_t b;
    lane_t a;
  } adc_word_t;

  // Clamp a 17-bit signed difference into the 16-bit lane range.
  function automatic lane_t sat16(input logic signed [LANE_WIDTH:0] x);
    if (x[LANE_WIDTH] != x[LANE_WIDTH-1])
      return x[LANE_WIDTH] ? lane_t'(16'sh8000) : lane_t'(16'sh7fff);
    else
      return x[LANE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pdh_lane_avg.sv
// One ADC lane: offset subtract with saturation, box-car accumulate, floor-shift.
// Latency: 2 clk from input valid to avg update on the window's last sample.
// Backpressure: none; accepts one sample per clk.
// Ports: clk/rst; in_vld, lane, offset (stage-1 inputs); s1_vld, acc_clr,
//        win_end, n (shared window control from the top); avg (held result),
//        sat (combinational saturation detect for the current input).
module pdh_lane_avg
  import pdh_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [15:0] lane,
  input  logic [15:0] offset,
  input  logic        s1_vld,
  input  logic        acc_clr,
  input  logic        win_end,
  input  logic [3:0]  n,
  output logic [15:0] avg,
  output logic        sat
);

  logic signed [LANE_WIDTH:0]  diff;
  lane_t                       s1_dat;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] shifted;

  assign diff = $signed({lane[15], lane}) - $signed({offset[15], offset});
  // Out of 16-bit range exactly when the two top bits of the 17-bit result differ.
  assign sat  = diff[LANE_WIDTH] != diff[LANE_WIDTH-1];

  // The window's last sample is folded in here so the result lands one clk after stage 1.
  assign sum     = acc + {{(ACC_WIDTH-LANE_WIDTH){s1_dat[LANE_WIDTH-1]}}, s1_dat};
  assign shifted = sum >>> n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_dat <= '0;
      acc    <= '0;
      avg    <= '0;
    end else begin
      if (in_vld)
        s1_dat <= sat16(diff);
      if (acc_clr) begin
        acc <= '0;
      end else if (s1_vld) begin
        if (win_end) begin
          avg <= shifted[LANE_WIDTH-1:0];
          acc <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: rtl/pdh_adc_decimator.sv
// ADC conditioning ahead of pdh_core: per-lane offset removal, 2^N box-car average, decimate.
// Latency: 2 clk from the last sample's adc_tvalid_i to the dat_tvalid_o pulse.
// Backpressure: none; one input per clk sustained, dat_tvalid_o is a single-cycle pulse.
// Ports: clk, rst (async active-high); adc_tdata_i/adc_tvalid_i {B,A} raw lanes;
//        offset_a_i/offset_b_i signed offsets; dec_log2_i exponent N (clamped to 8);
//        sat_clr_i clears the sticky flag; dat_tdata_o/dat_tvalid_o averaged {B,A};
//        sat_flag_o sticky saturation flag.
// Optional: define PDH_ADC_SAT_FLAG_EN to build the sticky saturation flag;
//           otherwise sat_flag_o is tied low and sat_clr_i is ignored.
module pdh_adc_decimator
  import pdh_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adc_tdata_i,
  input  logic        adc_tvalid_i,
  input  logic [15:0] offset_a_i,
  input  logic [15:0] offset_b_i,
  input  logic [3:0]  dec_log2_i,
  input  logic        sat_clr_i,
  output logic [31:0] dat_tdata_o,
  output logic        dat_tvalid_o,
  output logic        sat_flag_o
);

  adc_word_t                 adc_word;
  logic                      s1_vld;
  logic [3:0]                n_q;
  logic [3:0]                n_next;
  logic                      n_chg;
  logic [MAX_DEC_LOG2-1:0]   cnt;
  logic [MAX_DEC_LOG2:0]     win_mask;
  logic                      win_end;
  logic [15:0]               avg_a;
  logic [15:0]               avg_b;
  logic                      sat_a;
  logic                      sat_b;

  assign adc_word = adc_tdata_i;

  assign n_next   = (dec_log2_i > 4'(MAX_DEC_LOG2)) ? 4'(MAX_DEC_LOG2) : dec_log2_i;
  // A change of N abandons the partial window; the sample arriving in that cycle is dropped too.
  assign n_chg    = n_next != n_q;
  assign win_mask = (9'd1 << n_q) - 9'd1;
  assign win_end  = s1_vld && ({1'b0, cnt} == win_mask) && !n_chg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld       <= 1'b0;
      n_q          <= '0;
      cnt          <= '0;
      dat_tvalid_o <= 1'b0;
    end else begin
      s1_vld       <= adc_tvalid_i;
      n_q          <= n_next;
      dat_tvalid_o <= win_end;
      if (n_chg)
        cnt <= '0;
      else if (s1_vld)
        cnt <= win_end ? '0 : cnt + 1'b1;
    end
  end

  pdh_lane_avg u_lane_a (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (adc_tvalid_i),
    .lane    (adc_word.a),
    .offset  (offset_a_i),
    .s1_vld  (s1_vld),
    .acc_clr (n_chg),
    .win_end (win_end),
    .n       (n_q),
    .avg     (avg_a),
    .sat     (sat_a)
  );

  pdh_lane_avg u_lane_b (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (adc_tvalid_i),
    .lane    (adc_word.b),
    .offset  (offset_b_i),
    .s1_vld  (s1_vld),
    .acc_clr (n_chg),
    .win_end (win_end),
    .n       (n_q),
    .avg     (avg_b),
    .sat     (sat_b)
  );

  assign dat_tdata_o = {avg_b, avg_a};

`ifdef PDH_ADC_SAT_FLAG_EN
  // Set has priority over clear so a saturation in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_flag_o <= 1'b0;
    else if (adc_tvalid_i && (sat_a || sat_b))
      sat_flag_o <= 1'b1;
    else if (sat_clr_i)
      sat_flag_o <= 1'b0;
  end
`else
  logic unused_sat;
  assign unused_sat = ^{sat_a, sat_b, sat_clr_i};
  assign sat_flag_o = 1'b0;
`endif

endmodule

// File: tb/tb_pdh_adc_decimator.sv
// Self-checking bench for pdh_adc_decimator against an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pdh_adc_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adc_tdata_i;
  logic        adc_tvalid_i;
  logic [15:0] offset_a_i;
  logic [15:0] offset_b_i;
  logic [3:0]  dec_log2_i;
  logic        sat_clr_i;
  logic [31:0] dat_tdata_o;
  logic        dat_tvalid_o;
  logic        sat_flag_o;

  always #5 clk = ~clk;

  pdh_adc_decimator dut (
    .clk          (clk),
    .rst          (rst),
    .adc_tdata_i  (adc_tdata_i),
    .adc_tvalid_i (adc_tvalid_i),
    .offset_a_i   (offset_a_i),
    .offset_b_i   (offset_b_i),
    .dec_log2_i   (dec_log2_i),
    .sat_clr_i    (sat_clr_i),
    .dat_tdata_o  (dat_tdata_o),
    .dat_tvalid_o (dat_tvalid_o),
    .sat_flag_o   (sat_flag_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the specification's rules.
  typedef struct {
    int          due;
    logic [31:0] word;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  int          m_n;        // effective (clamped) N the DUT is using
  int          sum_a, sum_b, cnt;
  int          off_a, off_b;
  bit          m_flag;
  logic [31:0] last_word;

  function automatic int sat_val(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int floor_div(input int s, input int n);
    int d;
    d = 1 << n;
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic int clamp_n(input int n);
    return (n > 8) ? 8 : n;
  endfunction

  task automatic clear_window();
    sum_a = 0;
    sum_b = 0;
    cnt   = 0;
  endtask

  // One clock: drive inputs, advance the model, then sample the DUT 1 ns after the edge.
  task automatic step(input bit v, input int a, input int b, input bit clr);
    int          da, db, oa, ob;
    bit          sat_ev;
    bit          exp_v;
    logic [31:0] w;
    adc_tvalid_i = v;
    adc_tdata_i  = {b[15:0], a[15:0]};
    offset_a_i   = off_a[15:0];
    offset_b_i   = off_b[15:0];
    sat_clr_i    = clr;
    sat_ev = 1'b0;
    if (v) begin
      da = a - off_a;
      db = b - off_b;
      sat_ev = (da != sat_val(da)) || (db != sat_val(db));
      sum_a += sat_val(da);
      sum_b += sat_val(db);
      cnt++;
      if (cnt == (1 << m_n)) begin
        oa = floor_div(sum_a, m_n);
        ob = floor_div(sum_b, m_n);
        w  = {ob[15:0], oa[15:0]};
        q.push_back('{due: cyc + 2, word: w});
        clear_window();
      end
    end
`ifdef PDH_ADC_SAT_FLAG_EN
    if (sat_ev)   m_flag = 1'b1;
    else if (clr) m_flag = 1'b0;
`else
    m_flag = 1'b0;
`endif
    @(posedge clk);
    #1;
    cyc++;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    if (exp_v) begin
      last_word = q[0].word;
      void'(q.pop_front());
    end
    check("tvalid", {31'b0, dat_tvalid_o}, {31'b0, exp_v});
    check("tdata", dat_tdata_o, last_word);
    check("sat_flag", {31'b0, sat_flag_o}, {31'b0, m_flag});
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  // Change N while the pipeline is empty; a different effective N discards the partial window.
  task automatic set_n(input int n);
    dec_log2_i = n[3:0];
    if (clamp_n(n) != m_n) clear_window();
    m_n = clamp_n(n);
    idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_tdata", dat_tdata_o, 32'h0);
    check("rst_tvalid", {31'b0, dat_tvalid_o}, 32'h0);
    check("rst_flag", {31'b0, sat_flag_o}, 32'h0);
    q.delete();
    clear_window();
    last_word = '0;
    m_flag    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // N register restarts at 0 and reloads dec_log2_i; the idle cycles absorb that change.
    m_n = clamp_n(int'(dec_log2_i));
    idle(3);
  endtask

  initial begin
    adc_tdata_i  = '0;
    adc_tvalid_i = 1'b0;
    offset_a_i   = '0;
    offset_b_i   = '0;
    dec_log2_i   = '0;
    sat_clr_i    = 1'b0;
    off_a = 0; off_b = 0;
    cyc = 0; m_n = 0; m_flag = 1'b0; last_word = '0;
    clear_window();
    rst = 1'b0;
    #2;
    do_reset();

    // Pass-through at N=0.
    set_n(0);
    for (int i = 0; i < 3; i++) step(1'b1, 100, -100, 1'b0);
    idle(3);

    // Averaging at N=2 with input gaps.
    set_n(2);
    step(1'b1, 4, -4, 1'b0);
    idle(1);
    step(1'b1, 8, -8, 1'b0);
    step(1'b1, 12, -12, 1'b0);
    idle(2);
    step(1'b1, 16, -16, 1'b0);
    idle(3);

    // Flooring toward -inf.
    set_n(1);
    step(1'b1, -1, 1, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    idle(3);

    // Saturation boundary, sticky flag and clear.
    set_n(0);
    off_a = 16384;
    step(1'b1, -16384, 0, 1'b0);
    step(1'b1, -16385, 0, 1'b0);
    idle(2);
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, -16385, 0, 1'b1);   // set wins over clear
    step(1'b0, 0, 0, 1'b1);
    off_a = 0;
    idle(2);

    // N change mid-window discards the partial window.
    set_n(3);
    for (int i = 0; i < 5; i++) step(1'b1, 50 * i, -7 * i, 1'b0);
    set_n(1);
    step(1'b1, 30, 31, 1'b0);
    step(1'b1, 40, -31, 1'b0);
    idle(3);

    // Reset mid-window.
    set_n(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1000, 2000, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8 + i, -8 - i, 1'b0);
    idle(3);

    // Randomized traffic: random gaps, offsets, N (including clamped values) and clears.
    for (int blk = 0; blk < 12; blk++) begin
      set_n(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        off_a = int'($urandom_range(0, 65535)) - 32768;
        off_b = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        off_a = int'($urandom_range(0, 2047)) - 1024;
        off_b = int'($urandom_range(0, 2047)) - 1024;
      end
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          off_a = int'($urandom_range(0, 2047)) - 1024;
        end
        step($urandom_range(0, 9) < 7,
             int'($urandom_range(0, 16383)) - 8192,
             int'($urandom_range(0, 16383)) - 8192,
             $urandom_range(0, 19) == 0);
      end
      idle(3);
    end

    idle(4);
    check("drain", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
